// File: rtl/uart_pkg.sv
// Shared UART definitions: default frame width and receive-entry layout.
package uart_pkg;

  localparam int unsigned UART_WIDTH = 8;

  // Error flag sits just above the data field in a stored frame entry.
  localparam int unsigned ERR_BIT = UART_WIDTH;

  function automatic int unsigned err_bit(input int unsigned width);
    return width;
  endfunction

endpackage

// File: rtl/uart_rx_fifo_if.sv
// Host-side valid/ready bus of the receive FIFO.
interface uart_rx_fifo_if
  import uart_pkg::*;
#(
  parameter int unsigned WIDTH = UART_WIDTH
);

  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_data;
  logic             out_err;

  modport master (
    output out_valid,
    output out_data,
    output out_err,
    input  out_ready
  );

  modport slave (
    input  out_valid,
    input  out_data,
    input  out_err,
    output out_ready
  );

endinterface

// File: rtl/uart_sync_fifo.sv
// Generic first-word-fall-through FIFO; the caller must not push while full
// unless it pops in the same cycle.
module uart_sync_fifo #(
  parameter  int unsigned DW    = 9,
  parameter  int unsigned DEPTH = 16,
  localparam int unsigned AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          push,
  input  logic          pop,
  input  logic [DW-1:0] din,
  output logic [DW-1:0] dout,
  output logic [AW:0]   count,
  output logic          full,
  output logic          empty
);

  logic [DW-1:0] mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0]   count_q, count_d;
  logic          do_pop;

  assign do_pop = pop & ~empty;

  // Pointer and occupancy next-state; pointers wrap naturally at DEPTH.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push)   wr_ptr_d = wr_ptr_q + AW'(1);
    if (do_pop) rd_ptr_d = rd_ptr_q + AW'(1);
    case ({push, do_pop})
      2'b10:   count_d = count_q + (AW+1)'(1);
      2'b01:   count_d = count_q - (AW+1)'(1);
      default: count_d = count_q;
    endcase
  end

  // Pointer and occupancy registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage array; contents are intentionally not reset.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= din;
  end

  // When full with push and pop together, wr_ptr == rd_ptr: the head is read
  // combinationally this cycle and overwritten on the same edge.
  assign dout  = mem_q[rd_ptr_q];
  assign count = count_q;
  assign empty = (count_q == '0);
  assign full  = (count_q == (AW+1)'(DEPTH));

endmodule

// File: rtl/uart_rx_fifo.sv
// Receive buffer behind the UART receiver: captures one {error, data} entry
// per frame on the falling edge of rx_ready and queues it for the host.
module uart_rx_fifo
  import uart_pkg::*;
#(
  parameter int unsigned WIDTH  = UART_WIDTH,
  parameter int unsigned DEPTH  = 16,
  parameter int unsigned ADDR_W = $clog2(DEPTH)
) (
  input  logic              rx_clk,
  input  logic              rx_reset,
  input  logic              rx_ready,
  input  logic              rx_error,
  input  logic [WIDTH-1:0]  rx_data,
  uart_rx_fifo_if.master    host,
  output logic [ADDR_W:0]   count,
  output logic              full,
  output logic              overflow,
  input  logic              ovf_clr
);

  localparam int unsigned EW     = WIDTH + 1;
  localparam int unsigned ERR_IX = err_bit(WIDTH);

  logic          rdy_q;
  logic          ovf_q, ovf_d;
  logic          push_ev, pop, accept, drop, empty;
  logic [EW-1:0] entry_in, entry_out;

  // Delayed rx_ready; the cycle after its fall is the only one where the
  // receiver's data and stop-bit error are both final.
  always_ff @(posedge rx_clk or negedge rx_reset) begin
    if (!rx_reset) rdy_q <= 1'b0;
    else           rdy_q <= rx_ready;
  end

  assign push_ev = rdy_q & ~rx_ready;
  assign pop     = host.out_valid & host.out_ready;
  assign accept  = push_ev & (~full | pop);
  assign drop    = push_ev & full & ~pop;

  // Sticky overflow: a dropped frame wins over a clear in the same cycle.
  always_comb begin
    ovf_d = ovf_q;
    if (drop)         ovf_d = 1'b1;
    else if (ovf_clr) ovf_d = 1'b0;
  end

  // Overflow register.
  always_ff @(posedge rx_clk or negedge rx_reset) begin
    if (!rx_reset) ovf_q <= 1'b0;
    else           ovf_q <= ovf_d;
  end

  assign entry_in = {rx_error, rx_data};

  uart_sync_fifo #(
    .DW    (EW),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (rx_clk),
    .rst_n (rx_reset),
    .push  (accept),
    .pop   (pop),
    .din   (entry_in),
    .dout  (entry_out),
    .count (count),
    .full  (full),
    .empty (empty)
  );

  assign host.out_valid = ~empty;
  assign host.out_data  = entry_out[WIDTH-1:0];
  assign host.out_err   = entry_out[ERR_IX];
  assign overflow       = ovf_q;

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Self-checking bench for uart_rx_fifo: directed vector table, corner-case
// sequences and randomized traffic against a queue-based reference model.
module tb_uart_rx_fifo;

  localparam int unsigned W     = 8;
  localparam int unsigned DEPTH = 16;

  logic         rx_clk;
  logic         rx_reset;
  logic         rx_ready;
  logic         rx_error;
  logic [W-1:0] rx_data;
  logic [4:0]   count;
  logic         full;
  logic         overflow;
  logic         ovf_clr;

  int checks   = 0;
  int failures = 0;

  uart_rx_fifo_if #(.WIDTH(W)) bus ();

  uart_rx_fifo #(
    .WIDTH (W),
    .DEPTH (DEPTH)
  ) dut (
    .rx_clk   (rx_clk),
    .rx_reset (rx_reset),
    .rx_ready (rx_ready),
    .rx_error (rx_error),
    .rx_data  (rx_data),
    .host     (bus.master),
    .count    (count),
    .full     (full),
    .overflow (overflow),
    .ovf_clr  (ovf_clr)
  );

  initial rx_clk = 1'b0;
  always #5 rx_clk = ~rx_clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Reference model: queue of {err, data}, sticky flag, previous rx_ready.
  logic [W:0] mq[$];
  logic       m_ovf;
  logic       m_prev;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // One clock: apply inputs, advance the model, then compare after the edge.
  task automatic cycle(input logic rdy, input logic err, input logic [W-1:0] data,
                       input logic ordy, input logic clr);
    logic push, pop, drop;
    rx_ready      = rdy;
    rx_error      = err;
    rx_data       = data;
    bus.out_ready = ordy;
    ovf_clr       = clr;
    push = m_prev & ~rdy;
    pop  = (mq.size() != 0) && ordy;
    if (pop) void'(mq.pop_front());
    drop = push && (mq.size() >= DEPTH);
    if (push && !drop) mq.push_back({err, data});
    if (drop)     m_ovf = 1'b1;
    else if (clr) m_ovf = 1'b0;
    m_prev = rdy;
    @(posedge rx_clk);
    #1;
    chk("m_valid", int'(bus.out_valid), int'(mq.size() != 0));
    chk("m_count", int'(count), mq.size());
    chk("m_full", int'(full), int'(mq.size() == DEPTH));
    chk("m_ovf", int'(overflow), int'(m_ovf));
    if (mq.size() != 0) begin
      chk("m_data", int'(bus.out_data), int'(mq[0][W-1:0]));
      chk("m_err", int'(bus.out_err), int'(mq[0][W]));
    end
  endtask

  task automatic frame(input logic [W-1:0] data, input logic err, input int hi,
                       input logic ordy_fall, input logic clr_fall);
    repeat (hi) cycle(1'b1, ~err, ~data, 1'b0, 1'b0);
    cycle(1'b0, err, data, ordy_fall, clr_fall);
  endtask

  typedef struct {
    logic         rdy;
    logic         err;
    logic [W-1:0] data;
    logic         ordy;
    logic         clr;
    int           reps;
    logic         e_valid;
    logic [W-1:0] e_data;
    logic         e_err;
    int           e_count;
    logic         e_ovf;
  } vec_t;

  vec_t vecs[$];

  initial begin
    logic r;
    int   thr;
    logic re, ro, rc;
    logic [W-1:0] rd;

    rx_reset = 1'b0; rx_ready = 1'b0; rx_error = 1'b0; rx_data = '0;
    bus.out_ready = 1'b0; ovf_clr = 1'b0;
    mq.delete(); m_ovf = 1'b0; m_prev = 1'b0;

    repeat (2) @(posedge rx_clk);
    #1;
    chk("rst_valid", int'(bus.out_valid), 0);
    chk("rst_count", int'(count), 0);
    chk("rst_full", int'(full), 0);
    chk("rst_ovf", int'(overflow), 0);
    rx_reset = 1'b1;

    // Single frame, error frame, error toggling during high, rising edge only.
    vecs.push_back('{1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 16, 1'b0, 8'h00, 1'b0, 0, 1'b0});
    vecs.push_back('{1'b0, 1'b0, 8'hA5, 1'b0, 1'b0,  1, 1'b1, 8'hA5, 1'b0, 1, 1'b0});
    vecs.push_back('{1'b0, 1'b0, 8'h00, 1'b1, 1'b0,  1, 1'b0, 8'h00, 1'b0, 0, 1'b0});
    vecs.push_back('{1'b0, 1'b0, 8'h00, 1'b1, 1'b0,  2, 1'b0, 8'h00, 1'b0, 0, 1'b0});
    vecs.push_back('{1'b1, 1'b1, 8'h11, 1'b0, 1'b0,  5, 1'b0, 8'h00, 1'b0, 0, 1'b0});
    vecs.push_back('{1'b1, 1'b0, 8'h22, 1'b0, 1'b0,  5, 1'b0, 8'h00, 1'b0, 0, 1'b0});
    vecs.push_back('{1'b1, 1'b1, 8'h33, 1'b0, 1'b0,  3, 1'b0, 8'h00, 1'b0, 0, 1'b0});
    vecs.push_back('{1'b0, 1'b1, 8'h3C, 1'b0, 1'b0,  1, 1'b1, 8'h3C, 1'b1, 1, 1'b0});
    vecs.push_back('{1'b1, 1'b1, 8'h00, 1'b0, 1'b0,  4, 1'b1, 8'h3C, 1'b1, 1, 1'b0});
    vecs.push_back('{1'b0, 1'b0, 8'h5A, 1'b1, 1'b0,  1, 1'b1, 8'h5A, 1'b0, 1, 1'b0});
    vecs.push_back('{1'b0, 1'b0, 8'h00, 1'b1, 1'b0,  1, 1'b0, 8'h00, 1'b0, 0, 1'b0});

    foreach (vecs[i]) begin
      repeat (vecs[i].reps)
        cycle(vecs[i].rdy, vecs[i].err, vecs[i].data, vecs[i].ordy, vecs[i].clr);
      chk($sformatf("v%0d_valid", i), int'(bus.out_valid), int'(vecs[i].e_valid));
      chk($sformatf("v%0d_count", i), int'(count), vecs[i].e_count);
      chk($sformatf("v%0d_ovf", i), int'(overflow), int'(vecs[i].e_ovf));
      if (vecs[i].e_valid) begin
        chk($sformatf("v%0d_data", i), int'(bus.out_data), int'(vecs[i].e_data));
        chk($sformatf("v%0d_err", i), int'(bus.out_err), int'(vecs[i].e_err));
      end
    end

    // Fill, overflow drop, set-over-clear priority, in-order drain, clear.
    for (int i = 0; i < 16; i++) frame(8'(i), 1'b0, 3, 1'b0, 1'b0);
    chk("fill_full", int'(full), 1);
    chk("fill_count", int'(count), 16);
    chk("fill_ovf0", int'(overflow), 0);
    frame(8'hFF, 1'b0, 3, 1'b0, 1'b0);
    chk("drop_ovf", int'(overflow), 1);
    chk("drop_count", int'(count), 16);
    frame(8'hEE, 1'b0, 2, 1'b0, 1'b1);
    chk("set_prio_ovf", int'(overflow), 1);
    for (int i = 0; i < 16; i++) begin
      chk($sformatf("drain%0d", i), int'(bus.out_data), i);
      cycle(1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
    end
    chk("drained_valid", int'(bus.out_valid), 0);
    chk("drained_ovf", int'(overflow), 1);
    cycle(1'b0, 1'b0, 8'h00, 1'b0, 1'b1);
    chk("clr_ovf", int'(overflow), 0);

    // Full with a push coinciding with a pop.
    for (int i = 0; i < 16; i++) frame(8'(i), 1'b0, 2, 1'b0, 1'b0);
    repeat (3) cycle(1'b1, 1'b0, 8'h00, 1'b0, 1'b0);
    chk("fp_head", int'(bus.out_data), 0);
    cycle(1'b0, 1'b0, 8'hC3, 1'b1, 1'b0);
    chk("fp_count", int'(count), 16);
    chk("fp_ovf", int'(overflow), 0);
    chk("fp_head1", int'(bus.out_data), 1);
    for (int i = 1; i < 17; i++) begin
      chk($sformatf("fp_drain%0d", i), int'(bus.out_data), (i == 16) ? 8'hC3 : i);
      cycle(1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
    end
    chk("fp_empty", int'(bus.out_valid), 0);

    // Long rx_ready high still yields one entry.
    repeat (40) cycle(1'b1, 1'b0, 8'h00, 1'b0, 1'b0);
    cycle(1'b0, 1'b0, 8'h77, 1'b0, 1'b0);
    repeat (5) cycle(1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
    chk("long_count", int'(count), 1);
    chk("long_data", int'(bus.out_data), 8'h77);
    cycle(1'b0, 1'b0, 8'h00, 1'b1, 1'b0);

    // Asynchronous reset with five entries, overflow set and rx_ready high.
    for (int i = 0; i < 17; i++) frame(8'(8'h40 + i), 1'b0, 2, 1'b0, 1'b0);
    repeat (11) cycle(1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
    repeat (3) cycle(1'b1, 1'b0, 8'h00, 1'b0, 1'b0);
    chk("pre_rst_count", int'(count), 5);
    chk("pre_rst_ovf", int'(overflow), 1);
    #2 rx_reset = 1'b0;
    #1;
    chk("arst_count", int'(count), 0);
    chk("arst_valid", int'(bus.out_valid), 0);
    chk("arst_ovf", int'(overflow), 0);
    mq.delete(); m_ovf = 1'b0; m_prev = 1'b0;
    @(posedge rx_clk);
    #1 rx_reset = 1'b1;
    repeat (3) cycle(1'b1, 1'b0, 8'h00, 1'b0, 1'b0);
    cycle(1'b0, 1'b0, 8'h99, 1'b0, 1'b0);
    repeat (3) cycle(1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
    chk("post_rst_count", int'(count), 1);
    chk("post_rst_data", int'(bus.out_data), 8'h99);
    cycle(1'b0, 1'b0, 8'h00, 1'b1, 1'b0);

    // Randomized traffic in phases of low, medium and high drain rate.
    r = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      case ((i / 500) % 3)
        0:       thr = 0;
        1:       thr = 3;
        default: thr = 9;
      endcase
      if ($urandom_range(0, 3) == 0) r = ~r;
      re = 1'($urandom_range(0, 1));
      rd = 8'($urandom);
      ro = ($urandom_range(0, 9) < thr);
      rc = ($urandom_range(0, 40) == 0);
      cycle(r, re, rd, ro, rc);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
